stickman_motion: RTL and testbench

Vertical-motion controller for the stickman: the consumer side of the background block's ground-height interface. Once per frame it reads `GroundY`, the terrain height under the stickman column, together with the jump button. It integrates jump and gravity, lands on or falls past the terrain, and detects wall and pitfall deaths. It drives the stickman's foot Y to the sprite/ColorMapper logic and the game-over flag to the game FSM.

---
 rtl/stickman_pkg.sv | 20 ++
 rtl/frame_tick.sv | 26 ++
 rtl/stickman_motion.sv | 165 ++++++++++++++++
 tb/tb_stickman_motion.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stickman_pkg.sv
// Shared stickman types and constants, also used by the background block.
package stickman_pkg;

    localparam int PIT_Y       = 479;
    localparam int GROUND_INIT = 360;
    localparam int VEL_W       = 6;
    localparam int POS_W       = 11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StAir  = 2'd2,
        StDead = 2'd3
    } motion_state_t;

    function automatic logic [9:0] clamp_pos(input logic signed [POS_W-1:0] p);
        return p[POS_W-1] ? 10'd0 : p[9:0];
    endfunction

endpackage

// File: rtl/frame_tick.sv
// Turns the slow, asynchronous frame clock into a one-Clk tick on its rising edge.
module frame_tick
    import stickman_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic frame_dly;
    logic frame_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_dly  <= 1'b0;
            frame_prev <= 1'b0;
        end else begin
            frame_dly  <= frame_clk;
            frame_prev <= frame_dly;
        end
    end

    assign tick = frame_dly & ~frame_prev;

endmodule

// File: rtl/stickman_motion.sv
// Stickman vertical motion: jump/gravity integration, landing and death detection.
// Optional STICKMAN_DOUBLE_JUMP_EN allows one extra jump per airborne phase.
module stickman_motion #(
    parameter int GROUND_INIT = stickman_pkg::GROUND_INIT,
    parameter int PIT_Y       = stickman_pkg::PIT_Y,
    parameter int JUMP_V      = 12,
    parameter int GRAVITY     = 1,
    parameter int VMAX        = 15,
    parameter int STEP_TOL    = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       playing,
    input  logic       jump,
    input  logic [9:0] GroundY,
    output logic [9:0] StickY,
    output logic [1:0] StickState,
    output logic       landed,
    output logic       game_over
);
    import stickman_pkg::*;

    localparam int VS_W = VEL_W + 1;
    localparam logic [9:0]              PIT_U  = 10'(PIT_Y);
    localparam logic [9:0]              INIT_U = 10'(GROUND_INIT);
    localparam logic signed [POS_W-1:0] PIT_S  = POS_W'(PIT_Y);
    localparam logic signed [POS_W-1:0] JUMP_S = POS_W'(JUMP_V);
    localparam logic signed [POS_W-1:0] TOL_S  = POS_W'(STEP_TOL);
    localparam logic signed [VEL_W-1:0] VJUMP  = VEL_W'(-JUMP_V);
    localparam logic signed [VEL_W-1:0] VMAX_V = VEL_W'(VMAX);
    localparam logic signed [VS_W-1:0]  VMAX_S = VS_W'(VMAX);
    localparam logic signed [VS_W-1:0]  GRAV_S = VS_W'(GRAVITY);

    motion_state_t           state;
    logic [9:0]              stick_y;
    logic signed [VEL_W-1:0] vel;

    logic tick;
    logic jump_q, jump_pend, jump_rise, jump_now, air_jump;
    logic pit, land_ok;

    logic signed [POS_W-1:0] y_s, ground_s, ny, jump_y;
    logic signed [VS_W-1:0]  vel_sum;
    logic signed [VEL_W-1:0] vel_grav;

    frame_tick u_frame_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // A press landing in the tick cycle itself is honoured via the bypass.
    assign jump_rise = jump & ~jump_q;
    assign jump_now  = jump_pend | jump_rise;

    always_comb begin
        y_s      = signed'({1'b0, stick_y});
        ground_s = signed'({1'b0, GroundY});
        vel_sum  = VS_W'(vel) + GRAV_S;
        vel_grav = (vel_sum > VMAX_S) ? VMAX_V : vel_sum[VEL_W-1:0];
        ny       = y_s + POS_W'(vel_grav);
        jump_y   = y_s - JUMP_S;
        pit      = (GroundY == PIT_U);
        land_ok  = !vel_grav[VEL_W-1] && (vel_grav != '0) && !pit && (ny >= ground_s);
    end

`ifdef STICKMAN_DOUBLE_JUMP_EN
    logic air_jump_used;

    assign air_jump = jump_now & ~air_jump_used;

    always_ff @(posedge Clk) begin
        if (Reset || !playing || state == StIdle) begin
            air_jump_used <= 1'b0;
        end else if (tick && state == StAir) begin
            if (air_jump) begin
                air_jump_used <= 1'b1;
            end else if (land_ok) begin
                air_jump_used <= 1'b0;
            end
        end
    end
`else
    assign air_jump = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= StIdle;
            stick_y   <= INIT_U;
            vel       <= '0;
            jump_q    <= 1'b0;
            jump_pend <= 1'b0;
            landed    <= 1'b0;
            game_over <= 1'b0;
        end else begin
            jump_q <= jump;
            if (tick) begin
                jump_pend <= 1'b0;
            end else if (jump_rise) begin
                jump_pend <= 1'b1;
            end
            landed <= 1'b0;

            if (!playing) begin
                state     <= StIdle;
                stick_y   <= INIT_U;
                vel       <= '0;
                game_over <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        state   <= StRun;
                        stick_y <= GroundY;
                        vel     <= '0;
                    end
                    StRun: if (tick) begin
                        if (jump_now) begin
                            state   <= StAir;
                            stick_y <= clamp_pos(jump_y);
                            vel     <= jump_y[POS_W-1] ? '0 : VJUMP;
                        end else if (pit || ground_s > y_s) begin
                            state <= StAir;
                            vel   <= '0;
                        end else if (ground_s < y_s - TOL_S) begin
                            state     <= StDead;
                            game_over <= 1'b1;
                        end else begin
                            stick_y <= GroundY;
                        end
                    end
                    StAir: if (tick) begin
                        if (air_jump) begin
                            stick_y <= clamp_pos(jump_y);
                            vel     <= jump_y[POS_W-1] ? '0 : VJUMP;
                        end else if (land_ok) begin
                            state   <= StRun;
                            stick_y <= GroundY;
                            vel     <= '0;
                            landed  <= 1'b1;
                        end else if (ny >= PIT_S) begin
                            state     <= StDead;
                            stick_y   <= PIT_U;
                            game_over <= 1'b1;
                        end else if (ny[POS_W-1]) begin
                            stick_y <= '0;
                            vel     <= '0;
                        end else begin
                            stick_y <= ny[9:0];
                            vel     <= vel_grav;
                        end
                    end
                    StDead: ;
                    default: ;
                endcase
            end
        end
    end

    assign StickY     = stick_y;
    assign StickState = state;

endmodule

// File: tb/tb_stickman_motion.sv
// Self-checking bench for stickman_motion: directed vectors plus randomized run vs a model.
module tb_stickman_motion;

`ifdef STICKMAN_DOUBLE_JUMP_EN
    localparam bit DJ = 1'b1;
`else
    localparam bit DJ = 1'b0;
`endif
    localparam int GI = 360;
    localparam int PIT = 479;
    localparam int JV = 12;
    localparam int VMX = 15;
    localparam int TOL = 4;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       playing;
    logic       jump;
    logic [9:0] GroundY;
    logic [9:0] StickY;
    logic [1:0] StickState;
    logic       landed;
    logic       game_over;

    int checks = 0;
    int errors = 0;
    int land_cnt = 0;

    // reference model state (spec values: 0 idle, 1 run, 2 air, 3 dead)
    int m_st, m_y, m_v;
    bit m_fc1, m_fc2, m_jprev, m_jpend, m_landed, m_go, m_used;

    typedef struct {
        bit do_tick;
        bit pl;
        bit jp;
        int g;
        int exp_y;
        int exp_st;
        int exp_go;
        int exp_land;
    } vec_t;

    vec_t vecs[15];

    stickman_motion dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .playing    (playing),
        .jump       (jump),
        .GroundY    (GroundY),
        .StickY     (StickY),
        .StickState (StickState),
        .landed     (landed),
        .game_over  (game_over)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit tk, jr, jn;
        int g, nv, ny;
        if (Reset) begin
            m_st = 0; m_y = GI; m_v = 0;
            m_fc1 = 0; m_fc2 = 0; m_jprev = 0; m_jpend = 0;
            m_landed = 0; m_go = 0; m_used = 0;
            return;
        end
        g  = int'(GroundY);
        tk = m_fc1 && !m_fc2;
        jr = jump && !m_jprev;
        jn = m_jpend || jr;
        m_fc2 = m_fc1;
        m_fc1 = frame_clk;
        m_jprev = jump;
        if (tk) m_jpend = 0;
        else if (jr) m_jpend = 1;
        m_landed = 0;
        if (!playing) begin
            m_st = 0; m_y = GI; m_v = 0; m_go = 0; m_used = 0;
        end else if (m_st == 0) begin
            m_st = 1; m_y = g; m_v = 0; m_used = 0;
        end else if (m_st == 1 && tk) begin
            if (jn) begin
                m_st = 2; m_y = m_y - JV; m_v = -JV;
                if (m_y < 0) begin m_y = 0; m_v = 0; end
            end else if (g == PIT || g > m_y) begin
                m_st = 2; m_v = 0;
            end else if (g < m_y - TOL) begin
                m_st = 3; m_go = 1;
            end else begin
                m_y = g;
            end
        end else if (m_st == 2 && tk) begin
            nv = (m_v + 1 > VMX) ? VMX : m_v + 1;
            ny = m_y + nv;
            if (DJ && jn && !m_used) begin
                m_used = 1; m_y = m_y - JV; m_v = -JV;
                if (m_y < 0) begin m_y = 0; m_v = 0; end
            end else if (nv > 0 && g != PIT && ny >= g) begin
                m_st = 1; m_y = g; m_v = 0; m_landed = 1; m_used = 0;
            end else if (ny >= PIT) begin
                m_st = 3; m_y = PIT; m_go = 1;
            end else if (ny < 0) begin
                m_y = 0; m_v = 0;
            end else begin
                m_y = ny; m_v = nv;
            end
        end
    endtask

    // Inputs are changed only right after a falling edge; outputs compared at the falling edge.
    task automatic step();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        if (landed) land_cnt++;
        chk("model_y", int'(StickY), m_y);
        chk("model_state", int'(StickState), m_st);
        chk("model_landed", int'(landed), int'(m_landed));
        chk("model_game_over", int'(game_over), int'(m_go));
    endtask

    task automatic frame();
        frame_clk = 1'b1;
        repeat (4) step();
        frame_clk = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int l0;
        vecs[0]  = '{0, 1, 0, 360, 360, 1, 0, 0};
        vecs[1]  = '{1, 1, 0, 358, 358, 1, 0, 0};
        vecs[2]  = '{1, 1, 0, 360, 358, 2, 0, 0};
        vecs[3]  = '{1, 1, 0, 360, 359, 2, 0, 0};
        vecs[4]  = '{1, 1, 0, 360, 360, 1, 0, 1};
        vecs[5]  = '{1, 1, 0, 300, 360, 3, 1, 0};
        vecs[6]  = '{0, 0, 0, 300, 360, 0, 0, 0};
        vecs[7]  = '{0, 1, 0, 360, 360, 1, 0, 0};
        vecs[8]  = '{1, 1, 0, 479, 360, 2, 0, 0};
        vecs[9]  = '{1, 1, 0, 479, 361, 2, 0, 0};
        vecs[10] = '{0, 0, 0, 479, 360, 0, 0, 0};
        vecs[11] = '{0, 1, 0, 358, 358, 1, 0, 0};
        vecs[12] = '{1, 1, 1, 358, 346, 2, 0, 0};
        vecs[13] = '{1, 1, 0, 358, 335, 2, 0, 0};
        vecs[14] = '{0, 0, 0, 358, 360, 0, 0, 0};

        Reset = 1'b1; frame_clk = 1'b0; playing = 1'b0; jump = 1'b0; GroundY = 10'd360;
        @(negedge Clk);
        step();
        step();
        chk("reset_y", int'(StickY), 360);
        chk("reset_state", int'(StickState), 0);
        chk("reset_landed", int'(landed), 0);
        chk("reset_game_over", int'(game_over), 0);
        Reset = 1'b0;

        foreach (vecs[i]) begin
            playing = vecs[i].pl;
            jump    = vecs[i].jp;
            GroundY = 10'(vecs[i].g);
            l0 = land_cnt;
            if (vecs[i].do_tick) frame();
            else step();
            chk($sformatf("vec%0d_y", i), int'(StickY), vecs[i].exp_y);
            chk($sformatf("vec%0d_state", i), int'(StickState), vecs[i].exp_st);
            chk($sformatf("vec%0d_game_over", i), int'(game_over), vecs[i].exp_go);
            chk($sformatf("vec%0d_landed", i), land_cnt - l0, vecs[i].exp_land);
        end

        // full jump arc from flat ground
        playing = 1'b1; jump = 1'b0; GroundY = 10'd360;
        step();
        l0 = land_cnt;
        for (int t = 1; t <= 25; t++) begin
            jump = (t == 1);
            frame();
            if (t == 1) chk("arc_t1_y", int'(StickY), 348);
            if (t == 12) chk("arc_t12_y", int'(StickY), 282);
            if (t == 13) chk("arc_t13_y", int'(StickY), 282);
            if (t == 24) chk("arc_t24_state", int'(StickState), 2);
        end
        chk("arc_land_y", int'(StickY), 360);
        chk("arc_land_state", int'(StickState), 1);
        chk("arc_land_pulses", land_cnt - l0, 1);
        jump = 1'b0;

        // walk into a pit and fall to the death line
        GroundY = 10'd479;
        for (int f = 1; f <= 16; f++) begin
            frame();
            if (f == 15) begin
                chk("pit_f15_y", int'(StickY), 465);
                chk("pit_f15_state", int'(StickState), 2);
            end
        end
        chk("pit_dead_y", int'(StickY), 479);
        chk("pit_dead_state", int'(StickState), 3);
        chk("pit_dead_go", int'(game_over), 1);

        // jump edge in the very cycle of the tick over a pit
        playing = 1'b0; GroundY = 10'd360;
        step();
        playing = 1'b1;
        step();
        GroundY = 10'd479;
        frame_clk = 1'b1;
        step();
        jump = 1'b1;
        step();
        chk("same_cycle_jump_y", int'(StickY), 348);
        chk("same_cycle_jump_state", int'(StickState), 2);
        frame_clk = 1'b0; jump = 1'b0;
        repeat (3) step();

        // reset mid-air
        Reset = 1'b1;
        step();
        chk("midair_reset_y", int'(StickY), 360);
        chk("midair_reset_state", int'(StickState), 0);
        Reset = 1'b0;

        // second and third press while airborne
        playing = 1'b0; GroundY = 10'd360;
        step();
        playing = 1'b1;
        step();
        for (int t = 1; t <= 6; t++) begin
            jump = (t == 1);
            frame();
        end
        jump = 1'b1; frame();
        chk("air_press2_y", int'(StickY), DJ ? 291 : 297);
        jump = 1'b0; frame();
        chk("air_after2_y", int'(StickY), DJ ? 280 : 292);
        jump = 1'b1; frame();
        chk("air_press3_y", int'(StickY), DJ ? 270 : 288);
        jump = 1'b0; playing = 1'b0;
        step();

        // randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(0, 7) == 0) jump = ~jump;
            if (playing) begin
                if ($urandom_range(0, 299) == 0) playing = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                playing = 1'b1;
            end
            Reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: GroundY = 10'd360;
                    4:          GroundY = 10'd358;
                    5:          GroundY = 10'd479;
                    6:          GroundY = 10'd350;
                    7:          GroundY = 10'd362;
                    default:    GroundY = 10'($urandom_range(250, 420));
                endcase
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
